mem_bus_fabric: RTL and testbench

- Parametrised successor to the hard-wired SoC address decode and ready/rdata mux: one picorv32-style native memory master fanned out to NUM_SLAVES slave ports.
- Base/mask windows are set by parameter per slave.
- Adds a registered transaction FSM, a per-access timeout, unmapped-address error responses and error capture registers. The hand-written OR/mux chain at SoC top is replaced by this block.

---
 rtl/mem_bus_fabric.sv | 219 +++++++++++++++++++++
 tb/tb_mem_bus_fabric.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_fabric.sv
// mem_bus_fabric: fans one picorv32-style native memory master out to
// NUM_SLAVES slave ports selected by parameterised base/mask windows.
// A small transaction FSM adds a per-access timeout, error responses for
// unmapped addresses and error capture registers.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   mem_valid/addr/wdata/wstrb   master request (wdata goes to slaves externally)
//   mem_ready, mem_rdata         master response (rdata is 0 when not ready)
//   s_valid, s_ready, s_rdata    one-hot slave select, per-slave ready/rdata
//   bus_err                      pulse alongside an error mem_ready
//   err_addr/cause/write/count   capture of the most recent error, saturating count
module mem_bus_fabric #(
    parameter int unsigned               NUM_SLAVES     = 8,
    parameter logic [NUM_SLAVES*32-1:0]  SLAVE_BASE     = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES*32-1:0]  SLAVE_MASK     = {NUM_SLAVES{32'hFF00_0000}},
    parameter logic [15:0]               TIMEOUT_CYCLES = 16'd255,
    parameter logic [31:0]               ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     mem_valid,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              mem_wdata,
    input  logic [3:0]               mem_wstrb,
    output logic                     mem_ready,
    output logic [31:0]              mem_rdata,
    output logic [NUM_SLAVES-1:0]    s_valid,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    input  logic [NUM_SLAVES*32-1:0] s_rdata,
    output logic                     bus_err,
    output logic [31:0]              err_addr,
    output logic [1:0]               err_cause,
    output logic                     err_write,
    output logic [15:0]              err_count
);

    localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_ERR,
        ST_RECOVER
    } state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic                write_q, write_d;
    logic [31:0]         err_addr_q;
    logic [1:0]          err_cause_q;
    logic                err_write_q;
    logic [15:0]         err_count_q;

    logic                hit;
    logic [SEL_W-1:0]    dec_sel;
    logic [SEL_W-1:0]    cur_sel;
    logic                cur_ready;
    logic [31:0]         cur_rdata;

    logic [NUM_SLAVES-1:0] s_valid_c;
    logic                  mem_ready_c;
    logic [31:0]           mem_rdata_c;
    logic                  bus_err_c;
    logic [1:0]            cause_c;

    // Write data is routed to the slaves outside this block.
    logic unused_wdata;
    assign unused_wdata = ^mem_wdata;

    // Address decode; scanning from the top down lets the lowest index win on overlap.
    always_comb begin
        hit     = 1'b0;
        dec_sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((mem_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                dec_sel = SEL_W'(i);
            end
        end
    end

    // Ready/rdata mux for the slave currently being addressed.
    always_comb begin
        cur_sel   = (state_q == ST_ACTIVE) ? sel_q : dec_sel;
        cur_ready = 1'b0;
        cur_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (cur_sel == SEL_W'(i)) begin
                cur_ready = s_ready[i];
                cur_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    // Next-state and response logic.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        write_d     = write_q;
        s_valid_c   = '0;
        mem_ready_c = 1'b0;
        mem_rdata_c = '0;
        bus_err_c   = 1'b0;
        cause_c     = '0;

        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    addr_d  = mem_addr;
                    write_d = |mem_wstrb;
                    if (hit) begin
                        s_valid_c = NUM_SLAVES'(1) << dec_sel;
                        if (cur_ready) begin
                            mem_ready_c = 1'b1;
                            mem_rdata_c = cur_rdata;
                            state_d     = ST_RECOVER;
                        end else begin
                            sel_d   = dec_sel;
                            cnt_d   = '0;
                            state_d = ST_ACTIVE;
                        end
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end

            ST_ACTIVE: begin
                if (!mem_valid) begin
                    // Master abandoned the access: drop quietly, nothing logged.
                    state_d = ST_IDLE;
                end else if (cur_ready) begin
                    s_valid_c   = NUM_SLAVES'(1) << sel_q;
                    mem_ready_c = 1'b1;
                    mem_rdata_c = cur_rdata;
                    state_d     = ST_RECOVER;
                end else if ((TIMEOUT_CYCLES != 16'd0) && (cnt_q == TIMEOUT_CYCLES)) begin
                    mem_ready_c = 1'b1;
                    mem_rdata_c = ERR_RDATA;
                    bus_err_c   = 1'b1;
                    cause_c     = CAUSE_TIMEOUT;
                    state_d     = ST_RECOVER;
                end else begin
                    s_valid_c = NUM_SLAVES'(1) << sel_q;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_ERR: begin
                mem_ready_c = 1'b1;
                mem_rdata_c = ERR_RDATA;
                bus_err_c   = 1'b1;
                cause_c     = CAUSE_UNMAPPED;
                state_d     = ST_RECOVER;
            end

            ST_RECOVER: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, transaction context and error capture registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            err_addr_q  <= '0;
            err_cause_q <= '0;
            err_write_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            if (bus_err_c) begin
                err_addr_q  <= addr_q;
                err_cause_q <= cause_c;
                err_write_q <= write_q;
                if (err_count_q != 16'hFFFF) begin
                    err_count_q <= err_count_q + 16'd1;
                end
            end
        end
    end

    // Responses are combinational from IDLE; gate with resetn so an asserted
    // reset silences the bus immediately even while the master holds valid.
    assign s_valid   = resetn ? s_valid_c   : '0;
    assign mem_ready = resetn ? mem_ready_c : 1'b0;
    assign mem_rdata = resetn ? mem_rdata_c : '0;
    assign bus_err   = resetn ? bus_err_c   : 1'b0;

    assign err_addr  = err_addr_q;
    assign err_cause = err_cause_q;
    assign err_write = err_write_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Directed testbench for mem_bus_fabric: single-cycle slave, wait-state slave,
// unmapped access, timeout (with and without a last-cycle rescue), overlapping
// windows, master abort and asynchronous reset mid-transaction.
module tb_mem_bus_fabric;

    localparam int unsigned NS = 8;
    localparam logic [NS*32-1:0] BASE = {
        32'hA000_0000, 32'h6000_0000, 32'h5000_0000, 32'h4000_0000,
        32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NS*32-1:0] MASK = {
        32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000,
        32'hFF00_0000, 32'hFF00_0000, 32'hF000_0000, 32'hFF00_0000};
    localparam logic [7:0] R0 = 8'h01;  // slave 0 is always ready

    logic              clk;
    logic              resetn;
    logic              mem_valid;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic [NS-1:0]     s_valid;
    logic [NS-1:0]     s_ready;
    logic [NS*32-1:0]  s_rdata;
    logic              bus_err;
    logic [31:0]       err_addr;
    logic [1:0]        err_cause;
    logic              err_write;
    logic [15:0]       err_count;

    int checks;
    int failures;

    mem_bus_fabric #(
        .NUM_SLAVES     (NS),
        .SLAVE_BASE     (BASE),
        .SLAVE_MASK     (MASK),
        .TIMEOUT_CYCLES (16'd4),
        .ERR_RDATA      (32'hDEAD_BEEF)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata),
        .bus_err   (bus_err),
        .err_addr  (err_addr),
        .err_cause (err_cause),
        .err_write (err_write),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Apply one cycle of master/slave inputs just after the edge; return at the falling edge.
    task automatic step(input logic v, input logic [31:0] a, input logic [3:0] ws, input logic [7:0] r);
        @(posedge clk);
        #1;
        mem_valid = v;
        mem_addr  = a;
        mem_wstrb = ws;
        s_ready   = r;
        @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'h5555_AAAA;
        mem_wstrb = '0;
        s_ready   = R0;
        for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = 32'hA0A0_0000 | 32'(i);
        s_rdata[32*2 +: 32] = 32'h1234_5678;

        // Reset state
        #12;
        chk("rst_svalid", 32'(s_valid), 32'h0);
        chk("rst_ready", 32'(mem_ready), 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_cause", 32'(err_cause), 32'h0);
        chk("rst_count", 32'(err_count), 32'h0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // Always-ready slave 0 completes in the request cycle
        step(1'b1, 32'h0000_0010, 4'h0, R0);
        chk("s0_svalid", 32'(s_valid), 32'h01);
        chk("s0_ready", 32'(mem_ready), 32'h1);
        chk("s0_rdata", mem_rdata, 32'hA0A0_0000);
        step(1'b1, 32'h0000_0010, 4'h0, R0);
        chk("s0_rec_svalid", 32'(s_valid), 32'h0);
        chk("s0_rec_ready", 32'(mem_ready), 32'h0);
        chk("s0_rec_rdata", mem_rdata, 32'h0);
        step(1'b0, 32'h0, 4'h0, R0);

        // Slave 2 with three wait cycles
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'h2000_0004, 4'h0, R0);
            chk("s2_wait_svalid", 32'(s_valid), 32'h04);
            chk("s2_wait_ready", 32'(mem_ready), 32'h0);
            chk("s2_wait_rdata", mem_rdata, 32'h0);
        end
        step(1'b1, 32'h2000_0004, 4'h0, R0 | 8'h04);
        chk("s2_svalid", 32'(s_valid), 32'h04);
        chk("s2_ready", 32'(mem_ready), 32'h1);
        chk("s2_rdata", mem_rdata, 32'h1234_5678);
        chk("s2_buserr", 32'(bus_err), 32'h0);
        step(1'b0, 32'h0, 4'h0, R0);
        chk("s2_rec_svalid", 32'(s_valid), 32'h0);

        // Unmapped write
        step(1'b1, 32'h7000_0000, 4'hF, R0);
        chk("um_svalid0", 32'(s_valid), 32'h0);
        chk("um_ready0", 32'(mem_ready), 32'h0);
        step(1'b1, 32'h7000_0000, 4'hF, R0);
        chk("um_ready", 32'(mem_ready), 32'h1);
        chk("um_buserr", 32'(bus_err), 32'h1);
        chk("um_rdata", mem_rdata, 32'hDEAD_BEEF);
        chk("um_svalid1", 32'(s_valid), 32'h0);
        step(1'b0, 32'h0, 4'h0, R0);
        chk("um_buserr_off", 32'(bus_err), 32'h0);
        chk("um_cause", 32'(err_cause), 32'h1);
        chk("um_write", 32'(err_write), 32'h1);
        chk("um_addr", err_addr, 32'h7000_0000);
        chk("um_count", 32'(err_count), 32'h1);

        // Timeout: slave 2 never ready; error on 5th ACTIVE cycle
        step(1'b1, 32'h2000_0000, 4'h0, R0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 32'h2000_0000, 4'h0, R0);
            chk("to_wait_ready", 32'(mem_ready), 32'h0);
            chk("to_wait_svalid", 32'(s_valid), 32'h04);
        end
        step(1'b1, 32'h2000_0000, 4'h0, R0);
        chk("to_ready", 32'(mem_ready), 32'h1);
        chk("to_buserr", 32'(bus_err), 32'h1);
        chk("to_rdata", mem_rdata, 32'hDEAD_BEEF);
        chk("to_svalid", 32'(s_valid), 32'h0);
        step(1'b0, 32'h0, 4'h0, R0);
        chk("to_cause", 32'(err_cause), 32'h2);
        chk("to_write", 32'(err_write), 32'h0);
        chk("to_addr", err_addr, 32'h2000_0000);
        chk("to_count", 32'(err_count), 32'h2);

        // Ready on the timeout cycle: slave wins
        step(1'b1, 32'h2000_0008, 4'h0, R0);
        for (int k = 0; k < 4; k++) step(1'b1, 32'h2000_0008, 4'h0, R0);
        step(1'b1, 32'h2000_0008, 4'h0, R0 | 8'h04);
        chk("tr_ready", 32'(mem_ready), 32'h1);
        chk("tr_buserr", 32'(bus_err), 32'h0);
        chk("tr_rdata", mem_rdata, 32'h1234_5678);
        step(1'b0, 32'h0, 4'h0, R0);
        chk("tr_count", 32'(err_count), 32'h2);
        chk("tr_addr", err_addr, 32'h2000_0000);

        // Overlapping windows on slaves 1 and 3: lowest index wins
        step(1'b1, 32'h1000_0000, 4'h0, R0 | 8'h0A);
        chk("ov_svalid", 32'(s_valid), 32'h02);
        chk("ov_ready", 32'(mem_ready), 32'h1);
        chk("ov_rdata", mem_rdata, 32'hA0A0_0001);
        step(1'b0, 32'h0, 4'h0, R0);

        // Master abort in ACTIVE returns straight to IDLE
        step(1'b1, 32'h2000_0000, 4'h0, R0);
        step(1'b1, 32'h2000_0000, 4'h0, R0);
        step(1'b0, 32'h2000_0000, 4'h0, R0);
        chk("ab_svalid", 32'(s_valid), 32'h0);
        chk("ab_ready", 32'(mem_ready), 32'h0);
        step(1'b1, 32'h0000_0020, 4'h0, R0);
        chk("ab_next_ready", 32'(mem_ready), 32'h1);
        chk("ab_next_svalid", 32'(s_valid), 32'h01);
        chk("ab_count", 32'(err_count), 32'h2);
        step(1'b0, 32'h0, 4'h0, R0);

        // Asynchronous reset mid-ACTIVE
        step(1'b1, 32'h2000_0000, 4'h0, R0);
        step(1'b1, 32'h2000_0000, 4'h0, R0);
        chk("ar_pre_svalid", 32'(s_valid), 32'h04);
        #2 resetn = 1'b0;
        #1;
        chk("ar_svalid", 32'(s_valid), 32'h0);
        chk("ar_ready", 32'(mem_ready), 32'h0);
        chk("ar_count", 32'(err_count), 32'h0);
        chk("ar_cause", 32'(err_cause), 32'h0);
        chk("ar_addr", err_addr, 32'h0);
        mem_valid = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        step(1'b1, 32'h0000_0030, 4'h0, R0);
        chk("ar_idle_ready", 32'(mem_ready), 32'h1);
        chk("ar_idle_rdata", mem_rdata, 32'hA0A0_0000);
        chk("ar_idle_count", 32'(err_count), 32'h0);
        step(1'b0, 32'h0, 4'h0, R0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
